// File: rtl/dmem_responder.sv
// Memory-side responder for the datapath load/store request interface.
// One request at a time, performed after LATENCY edges, result held until the initiator takes it.
module dmem_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HI_W  = ADDR_WIDTH - 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg;
    logic                    write_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    error_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    access;
    logic                    addr_bad;
    logic                    mem_we;
    logic [HI_W-1:0]         word_full;
    logic [IDX_W-1:0]        word_idx;

    // The full upper address is compared so stray high bits flag an error instead of aliasing.
    assign word_full = addr_reg[ADDR_WIDTH-1:3];
    assign word_idx  = word_full[IDX_W-1:0];
    assign addr_bad  = (addr_reg[2:0] != 3'b000) || (word_full >= HI_W'(DEPTH));
    assign mem_we    = access && write_reg && !addr_bad && reset;

    assign req_ready  = (state_reg == IDLE) && reset;
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_error = error_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                cnt_reg   <= 4'(LATENCY - 1);
            end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (access) begin
                error_reg <= addr_bad;
                rdata_reg <= (write_reg || addr_bad) ? '0 : mem[word_idx];
            end else if ((state_reg == RESP) && resp_ready) begin
                error_reg <= 1'b0;
                rdata_reg <= '0;
            end
        end
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wdata_reg;
        end
    end

endmodule
